// File: rtl/cdbus_rx_byte.sv
// cdbus_rx_byte: RS485 byte receiver (8N1, LSB first) with idle-gap frame end detection.
// Parameters: CLK_DIV   clk cycles per bit (4..65535)
//             IDLE_BITS idle bit times that terminate a frame (1..255)
// Ports:      clk, reset_n (async, active-low), rx (async line, idle high)
//             data       last correctly received byte
//             data_valid one-cycle pulse, data is new this cycle
//             frame_err  one-cycle pulse, stop bit sampled low
//             frame_end  one-cycle pulse, idle gap seen after at least one byte
//             busy       high while the receiver is not idle
module cdbus_rx_byte #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned IDLE_BITS = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       frame_end,
  output logic       busy
);

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned IDLE_W = 24;
  localparam int unsigned BIT_W  = 3;

  // Divider reload values: half a bit to reach mid-start, then one full bit per sample.
  localparam logic [DIV_W-1:0]  DIV_HALF   = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0]  DIV_FULL   = DIV_W'(CLK_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_BITS * CLK_DIV);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_e;

  state_e              state_q,      state_d;
  logic                sync1_q,      sync1_d;
  logic                rx_s_q,       rx_s_d;
  logic                rx_d_q,       rx_d_d;
  logic [DIV_W-1:0]    div_q,        div_d;
  logic [BIT_W-1:0]    bit_q,        bit_d;
  logic [7:0]          shift_q,      shift_d;
  logic [7:0]          data_q,       data_d;
  logic                data_valid_q, data_valid_d;
  logic                frame_err_q,  frame_err_d;
  logic                frame_end_q,  frame_end_d;
  logic                busy_q,       busy_d;
  logic                got_byte_q,   got_byte_d;
  logic [IDLE_W-1:0]   idle_q,       idle_d;

  logic                start_edge;
  logic                tick;
  logic                idle_en;
  logic [IDLE_W-1:0]   idle_inc;

  // Next-state, datapath and output pulses.
  always_comb begin
    state_d      = state_q;
    sync1_d      = rx;
    rx_s_d       = sync1_q;
    rx_d_d       = rx_s_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    frame_end_d  = 1'b0;
    got_byte_d   = got_byte_q;
    idle_d       = '0;

    // Both sync stages reset low, so a line held low through reset never looks like an edge.
    start_edge = rx_d_q & ~rx_s_q;
    tick       = (div_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_START;
          bit_d   = '0;
          div_d   = DIV_HALF;
        end
      end
      ST_START: begin
        if (!tick) begin
          div_d = div_q - DIV_W'(1);
        end else if (rx_s_q) begin
          state_d = ST_IDLE;  // start bit gone by mid-bit: treat as glitch
        end else begin
          state_d = ST_DATA;
          div_d   = DIV_FULL;
        end
      end
      ST_DATA: begin
        if (!tick) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          div_d   = DIV_FULL;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(7)) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (!tick) begin
          div_d = div_q - DIV_W'(1);
        end else if (rx_s_q) begin
          data_d       = shift_q;
          data_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);

    // Idle gap timer; the start-edge cycle still counts so a gap ending on an edge is not lost.
    got_byte_d = got_byte_d | data_valid_d;
    idle_en    = (state_q == ST_IDLE) && got_byte_q && (rx_s_q || start_edge);
    idle_inc   = idle_q + IDLE_W'(1);
    if (idle_en) begin
      idle_d = idle_inc;
      if (idle_inc == IDLE_LIMIT) begin
        frame_end_d = 1'b1;
        idle_d      = '0;
        got_byte_d  = 1'b0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b0;
      rx_s_q       <= 1'b0;
      rx_d_q       <= 1'b0;
      div_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_end_q  <= 1'b0;
      busy_q       <= 1'b0;
      got_byte_q   <= 1'b0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      rx_s_q       <= rx_s_d;
      rx_d_q       <= rx_d_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      frame_end_q  <= frame_end_d;
      busy_q       <= busy_d;
      got_byte_q   <= got_byte_d;
      idle_q       <= idle_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign frame_end  = frame_end_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cdbus_rx_byte.sv
// tb_cdbus_rx_byte: directed bench for cdbus_rx_byte at CLK_DIV=8, IDLE_BITS=10.
// Cycle numbers are bench clock edges; n0 is the edge after which the start bit is driven,
// so the DUT start-detect cycle is T=n0+2 and stop-sample results appear at edge n0+79.
module tb_cdbus_rx_byte;

  localparam int unsigned CLK_DIV   = 8;
  localparam int unsigned IDLE_BITS = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       frame_end;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_dv = 0, n_fe = 0, n_fend = 0;
  int last_dv = -1, last_fe = -1, last_fend = -1;
  logic tx_active = 1'b0;

  cdbus_rx_byte #(.CLK_DIV(CLK_DIV), .IDLE_BITS(IDLE_BITS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .frame_end  (frame_end),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (data_valid) begin n_dv++;   last_dv   = cyc; end
    if (frame_err)  begin n_fe++;   last_fe   = cyc; end
    if (frame_end)  begin n_fend++; last_fend = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to the middle (negedge + 1) of the cycle following edge t.
  task automatic at_cyc(input int t);
    if (cyc > t) chk("bench_order", 32'(cyc), 32'(t));
    do @(negedge clk); while (cyc < t);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 8N1 frame, LSB first; stop level and extra low bit times after a bad stop are selectable.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low);
    tx_active = 1'b1;
    rx = 1'b0;
    repeat (CLK_DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (CLK_DIV * (1 + extra_low)) @(posedge clk);
    #1;
    rx = 1'b1;
    tx_active = 1'b0;
  endtask

  task automatic wait_tx();
    int budget;
    budget = 2000;
    while (tx_active && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    chk("tx_timeout", 32'(tx_active), 32'(0));
  endtask

  initial begin
    int n0, n1, n2, dv0, fe0, fe_n0;

    // Reset values.
    at_cyc(2);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_dv", 32'(data_valid), 32'(0));
    chk("rst_fe", 32'(frame_err), 32'(0));
    chk("rst_fend", 32'(frame_end), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycles(10);

    // Good byte 0xA5: data_valid exactly at T+77, busy low there.
    n0 = cyc;
    fork send_frame(8'hA5, 1'b1, 0); join_none
    at_cyc(n0 + 78);
    chk("a5_dv_early", 32'(data_valid), 32'(0));
    chk("a5_busy_stop", 32'(busy), 32'(1));
    at_cyc(n0 + 79);
    chk("a5_dv", 32'(data_valid), 32'(1));
    chk("a5_data", 32'(data), 32'hA5);
    chk("a5_busy_low", 32'(busy), 32'(0));
    at_cyc(n0 + 80);
    chk("a5_dv_single", 32'(data_valid), 32'(0));
    wait_tx();
    // Idle gap after 0xA5 ends the frame 80 cycles after IDLE entry.
    at_cyc(n0 + 170);
    chk("a5_fend_cnt", 32'(n_fend), 32'(1));
    chk("a5_fend_cyc", 32'(last_fend), 32'(n0 + 159));

    // 0x3C with low stop bit held low 3 more bit times.
    dv0 = n_dv;
    n0 = cyc;
    fork send_frame(8'h3C, 1'b0, 3); join_none
    at_cyc(n0 + 79);
    chk("3c_fe", 32'(frame_err), 32'(1));
    chk("3c_data_kept", 32'(data), 32'hA5);
    at_cyc(n0 + 80);
    chk("3c_fe_single", 32'(frame_err), 32'(0));
    at_cyc(n0 + 106);
    chk("3c_busy_wait", 32'(busy), 32'(1));
    at_cyc(n0 + 107);
    chk("3c_busy_low", 32'(busy), 32'(0));
    wait_tx();
    at_cyc(n0 + 250);
    chk("3c_no_dv", 32'(n_dv), 32'(dv0));
    chk("3c_no_fend", 32'(n_fend), 32'(1));

    // Two-cycle low glitch: START entered, rejected at mid-bit.
    dv0 = n_dv;
    fe0 = n_fe;
    @(posedge clk); #1;
    n0 = cyc;
    rx = 1'b0;
    idle_cycles(2);
    rx = 1'b1;
    at_cyc(n0 + 6);
    chk("gl_busy_sample", 32'(busy), 32'(1));
    at_cyc(n0 + 7);
    chk("gl_busy_low", 32'(busy), 32'(0));
    at_cyc(n0 + 40);
    chk("gl_pulses", 32'(n_dv + n_fe + n_fend), 32'(dv0 + fe0 + 1));

    // Back-to-back 0x01, 0x02, then one frame_end only.
    dv0 = n_dv;
    n1 = cyc;
    fork send_frame(8'h01, 1'b1, 0); join_none
    at_cyc(n1 + 79);
    chk("b1_dv", 32'(data_valid), 32'(1));
    chk("b1_data", 32'(data), 32'h01);
    wait_tx();
    n2 = cyc;
    chk("b2_back_to_back", 32'(n2), 32'(n1 + 80));
    fork send_frame(8'h02, 1'b1, 0); join_none
    at_cyc(n2 + 79);
    chk("b2_dv", 32'(data_valid), 32'(1));
    chk("b2_data", 32'(data), 32'h02);
    wait_tx();
    at_cyc(n2 + 158);
    chk("b2_fend_early", 32'(frame_end), 32'(0));
    at_cyc(n2 + 159);
    chk("b2_fend", 32'(frame_end), 32'(1));
    at_cyc(n2 + 160);
    chk("b2_fend_single", 32'(frame_end), 32'(0));
    at_cyc(n2 + 260);
    chk("b2_dv_cnt", 32'(n_dv), 32'(dv0 + 2));
    chk("b2_fend_cnt", 32'(n_fend), 32'(2));

    // Reset during bit 4 of 0xFF, then 0x55.
    dv0 = n_dv;
    fe0 = n_fe;
    fe_n0 = n_fend;
    n0 = cyc;
    fork send_frame(8'hFF, 1'b1, 0); join_none
    at_cyc(n0 + 44);
    reset_n = 1'b0;
    #1;
    chk("ab_rst_busy", 32'(busy), 32'(0));
    chk("ab_rst_data", 32'(data), 32'h00);
    #20;
    reset_n = 1'b1;
    wait_tx();
    idle_cycles(100);
    chk("ab_no_pulse", 32'(n_dv + n_fe + n_fend), 32'(dv0 + fe0 + fe_n0));
    chk("ab_busy", 32'(busy), 32'(0));
    n0 = cyc;
    fork send_frame(8'h55, 1'b1, 0); join_none
    at_cyc(n0 + 79);
    chk("55_dv", 32'(data_valid), 32'(1));
    chk("55_data", 32'(data), 32'h55);
    wait_tx();
    at_cyc(n0 + 170);

    // Line low through reset release: no start until a real falling edge.
    @(posedge clk); #1;
    reset_n = 1'b0;
    rx = 1'b0;
    idle_cycles(3);
    reset_n = 1'b1;
    idle_cycles(10);
    chk("lo_busy", 32'(busy), 32'(0));
    rx = 1'b1;
    idle_cycles(20);
    chk("hi_busy", 32'(busy), 32'(0));
    dv0 = n_dv;
    n0 = cyc;
    fork send_frame(8'h81, 1'b1, 0); join_none
    at_cyc(n0 + 79);
    chk("81_dv", 32'(data_valid), 32'(1));
    chk("81_data", 32'(data), 32'h81);
    wait_tx();
    idle_cycles(5);
    chk("81_dv_cnt", 32'(n_dv), 32'(dv0 + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
